// File: rtl/audio_delay_line.sv
// rtl/audio_delay_line.sv - feedback echo/delay engine over a circular two-cycle-latency block RAM
module audio_delay_line #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 96000,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int GAIN_W = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     audio_valid_in,
    input  logic signed [WIDTH-1:0]  audio_in,
    input  logic                     store_audio_in,
    input  logic [ADDR_W-1:0]        delay_in,
    input  logic [GAIN_W-1:0]        feedback_gain_in,
    input  logic [GAIN_W-1:0]        mix_gain_in,
    output logic signed [WIDTH-1:0]  signal_out,
    output logic signed [WIDTH-1:0]  echo_out,
    output logic signed [WIDTH-1:0]  mix_out,
    output logic                     out_valid,
    output logic                     busy_out,
    output logic                     overrun_out
);

    localparam int IW = WIDTH + GAIN_W + 1;
    localparam logic [ADDR_W:0]           DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0]         DEPTH_M1 = ADDR_W'(DEPTH - 1);
    localparam logic signed [IW-1:0]      SAT_MAX  = {{(GAIN_W+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [IW-1:0]      SAT_MIN  = {{(GAIN_W+2){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RD1, S_RD2, S_CALC} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]         fill_q, fill_d;
    logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]         delay_q, delay_d;
    logic signed [WIDTH-1:0]   sample_q, sample_d;
    logic                      store_q, store_d;
    logic [GAIN_W-1:0]         fb_gain_q, fb_gain_d;
    logic [GAIN_W-1:0]         mix_gain_q, mix_gain_d;
    logic signed [WIDTH-1:0]   signal_q, signal_d;
    logic signed [WIDTH-1:0]   echo_q, echo_d;
    logic signed [WIDTH-1:0]   mix_q, mix_d;
    logic                      out_valid_q, out_valid_d;
    logic                      overrun_q, overrun_d;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [WIDTH-1:0]          rd_stage_q;
    logic [WIDTH-1:0]          rd_data_q;
    logic                      rd_en;
    logic                      wr_en;

    logic [ADDR_W-1:0]         delay_clamped;
    logic [ADDR_W:0]           rd_full;
    logic [ADDR_W:0]           wr_x;
    logic [ADDR_W:0]           d_x;

    logic signed [WIDTH-1:0]   echo_w;
    logic signed [IW-1:0]      echo_x;
    logic signed [IW-1:0]      sample_x;
    logic signed [IW-1:0]      fb_gain_x;
    logic signed [IW-1:0]      mix_gain_x;
    logic signed [IW-1:0]      fb_prod;
    logic signed [IW-1:0]      wet_prod;
    logic signed [IW-1:0]      fb_val;
    logic signed [IW-1:0]      wet_val;
    logic signed [IW-1:0]      wsum;
    logic signed [IW-1:0]      msum;
    logic signed [WIDTH-1:0]   wdata;
    logic signed [WIDTH-1:0]   mix_sat;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[WIDTH-1:0];
        end else begin
            return v[WIDTH-1:0];
        end
    endfunction

    // Delay clamp and circular read address; no power-of-two depth is assumed.
    always_comb begin
        delay_clamped = delay_in;
        if (delay_in == '0) begin
            delay_clamped = ADDR_W'(1);
        end else if ({1'b0, delay_in} >= DEPTH_X) begin
            delay_clamped = DEPTH_M1;
        end
        wr_x = {1'b0, wr_ptr_q};
        d_x  = {1'b0, delay_clamped};
        if (wr_x >= d_x) begin
            rd_full = wr_x - d_x;
        end else begin
            rd_full = wr_x + DEPTH_X - d_x;
        end
    end

    // Echo datapath, evaluated against the latched per-sample parameters.
    always_comb begin
        echo_w     = (fill_q >= delay_q) ? $signed(rd_data_q) : '0;
        echo_x     = {{(GAIN_W+1){echo_w[WIDTH-1]}}, echo_w};
        sample_x   = {{(GAIN_W+1){sample_q[WIDTH-1]}}, sample_q};
        fb_gain_x  = {{(WIDTH+1){1'b0}}, fb_gain_q};
        mix_gain_x = {{(WIDTH+1){1'b0}}, mix_gain_q};
        fb_prod    = echo_x * fb_gain_x;
        wet_prod   = echo_x * mix_gain_x;
        fb_val     = fb_prod >>> (GAIN_W - 1);
        wet_val    = wet_prod >>> (GAIN_W - 1);
        wsum       = store_q ? (sample_x + fb_val) : fb_val;
        msum       = sample_x + wet_val;
        wdata      = sat(wsum);
        mix_sat    = sat(msum);
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        rd_addr_d   = rd_addr_q;
        delay_d     = delay_q;
        sample_d    = sample_q;
        store_d     = store_q;
        fb_gain_d   = fb_gain_q;
        mix_gain_d  = mix_gain_q;
        signal_d    = signal_q;
        echo_d      = echo_q;
        mix_d       = mix_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q | (audio_valid_in && (state_q != S_IDLE));
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (audio_valid_in) begin
                    sample_d   = audio_in;
                    store_d    = store_audio_in;
                    fb_gain_d  = feedback_gain_in;
                    mix_gain_d = mix_gain_in;
                    delay_d    = delay_clamped;
                    rd_addr_d  = rd_full[ADDR_W-1:0];
                    state_d    = S_RD1;
                end
            end
            S_RD1: begin
                rd_en   = 1'b1;
                state_d = S_RD2;
            end
            S_RD2: begin
                rd_en   = 1'b1;
                state_d = S_CALC;
            end
            S_CALC: begin
                wr_en       = !rst_in;
                wr_ptr_d    = (wr_ptr_q == DEPTH_M1) ? '0 : wr_ptr_q + 1'b1;
                fill_d      = (fill_q == DEPTH_M1) ? fill_q : fill_q + 1'b1;
                signal_d    = sample_q;
                echo_d      = echo_w;
                mix_d       = mix_sat;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            rd_addr_q   <= '0;
            delay_q     <= ADDR_W'(1);
            sample_q    <= '0;
            store_q     <= 1'b0;
            fb_gain_q   <= '0;
            mix_gain_q  <= '0;
            signal_q    <= '0;
            echo_q      <= '0;
            mix_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            rd_addr_q   <= rd_addr_d;
            delay_q     <= delay_d;
            sample_q    <= sample_d;
            store_q     <= store_d;
            fb_gain_q   <= fb_gain_d;
            mix_gain_q  <= mix_gain_d;
            signal_q    <= signal_d;
            echo_q      <= echo_d;
            mix_q       <= mix_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Block RAM: contents survive reset; read pipeline is address reg plus output reg.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wdata;
        end
        if (rd_en) begin
            rd_stage_q <= mem[rd_addr_q];
            rd_data_q  <= rd_stage_q;
        end
    end

    assign signal_out  = signal_q;
    assign echo_out    = echo_q;
    assign mix_out     = mix_q;
    assign out_valid   = out_valid_q;
    assign busy_out    = (state_q != S_IDLE);
    assign overrun_out = overrun_q;

endmodule

// File: tb/tb_audio_delay_line.sv
// tb/tb_audio_delay_line.sv - directed self-checking bench for audio_delay_line (small-depth build)
module tb_audio_delay_line;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 7;
    localparam int ADDR_W = 4;
    localparam int GAIN_W = 8;

    logic                     clk = 1'b0;
    logic                     rst_in;
    logic                     audio_valid_in;
    logic signed [WIDTH-1:0]  audio_in;
    logic                     store_audio_in;
    logic [ADDR_W-1:0]        delay_in;
    logic [GAIN_W-1:0]        feedback_gain_in;
    logic [GAIN_W-1:0]        mix_gain_in;
    logic signed [WIDTH-1:0]  signal_out;
    logic signed [WIDTH-1:0]  echo_out;
    logic signed [WIDTH-1:0]  mix_out;
    logic                     out_valid;
    logic                     busy_out;
    logic                     overrun_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_delay_line #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .GAIN_W (GAIN_W)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .audio_valid_in   (audio_valid_in),
        .audio_in         (audio_in),
        .store_audio_in   (store_audio_in),
        .delay_in         (delay_in),
        .feedback_gain_in (feedback_gain_in),
        .mix_gain_in      (mix_gain_in),
        .signal_out       (signal_out),
        .echo_out         (echo_out),
        .mix_out          (mix_out),
        .out_valid        (out_valid),
        .busy_out         (busy_out),
        .overrun_out      (overrun_out)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst_in         = 1'b1;
        audio_valid_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_in = 1'b0;
    endtask

    // One accepted sample; returns captured outputs and the out_valid latency (-1 when out_valid never rises).
    task automatic do_sample(input int s_val, input logic st, input logic [ADDR_W-1:0] d,
                             input logic [GAIN_W-1:0] fbg, input logic [GAIN_W-1:0] mxg,
                             output logic signed [WIDTH-1:0] s_o, output logic signed [WIDTH-1:0] e_o,
                             output logic signed [WIDTH-1:0] m_o, output int lat);
        @(negedge clk);
        audio_in         = WIDTH'(s_val);
        store_audio_in   = st;
        delay_in         = d;
        feedback_gain_in = fbg;
        mix_gain_in      = mxg;
        audio_valid_in   = 1'b1;
        @(negedge clk);
        audio_valid_in = 1'b0;
        lat = -1;
        s_o = 'x;
        e_o = 'x;
        m_o = 'x;
        for (int i = 0; i < 8; i++) begin
            if (out_valid && lat < 0) begin
                lat = i + 1;
                s_o = signal_out;
                e_o = echo_out;
                m_o = mix_out;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (signal_out !== '0 || echo_out !== '0 || mix_out !== '0 ||
            out_valid !== 1'b0 || busy_out !== 1'b0 || overrun_out !== 1'b0) begin
            errors++;
            $display("FAIL reset: sig=%0d echo=%0d mix=%0d ov=%b busy=%b ovr=%b, all required 0",
                     signal_out, echo_out, mix_out, out_valid, busy_out, overrun_out);
        end
        rst_in = 1'b0;
    endtask

    task automatic test_impulse();
        int exp_e[8] = '{0, 0, 0, 0, 1000, 0, 0, 0};
        int exp_m[8] = '{1000, 0, 0, 0, 1000, 0, 0, 0};
        logic signed [WIDTH-1:0] s, e, m;
        int lat;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            do_sample((k == 0) ? 1000 : 0, 1'b1, 4'd4, 8'd0, 8'd128, s, e, m, lat);
            checks++;
            if (lat != 4 || int'(e) !== exp_e[k] || int'(m) !== exp_m[k]) begin
                errors++;
                $display("FAIL impulse out%0d: lat=%0d echo=%0d mix=%0d, required lat=4 echo=%0d mix=%0d",
                         k + 1, lat, e, m, exp_e[k], exp_m[k]);
            end
        end
    endtask

    // Negative run uses -8001 so each halving lands on .5 and must floor.
    task automatic test_feedback();
        int exp_pos[9] = '{0, 0, 8000, 0, 4000, 0, 2000, 0, 1000};
        int exp_neg[9] = '{0, 0, -8001, 0, -4001, 0, -2001, 0, -1001};
        logic signed [WIDTH-1:0] s, e, m;
        int lat;
        int ex;
        for (int r = 0; r < 2; r++) begin
            apply_reset();
            for (int k = 0; k < 9; k++) begin
                do_sample((k == 0) ? ((r == 0) ? 8000 : -8001) : 0, (k == 0), 4'd2, 8'd64, 8'd128,
                          s, e, m, lat);
                ex = (r == 0) ? exp_pos[k] : exp_neg[k];
                checks++;
                if (lat != 4 || int'(e) !== ex) begin
                    errors++;
                    $display("FAIL feedback run%0d out%0d: echo=%0d lat=%0d, required echo=%0d lat=4",
                             r, k + 1, e, lat, ex);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int in_v[4]  = '{30000, 30000, -30000, -30000};
        int exp_e[4] = '{0, 30000, 30000, -30000};
        int exp_m[4] = '{30000, 32767, 0, -32768};
        logic signed [WIDTH-1:0] s, e, m;
        int lat;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            do_sample(in_v[k], 1'b1, 4'd1, 8'd0, 8'd128, s, e, m, lat);
            checks++;
            if (lat != 4 || int'(e) !== exp_e[k] || int'(m) !== exp_m[k]) begin
                errors++;
                $display("FAIL saturation out%0d: echo=%0d mix=%0d, required echo=%0d mix=%0d",
                         k + 1, e, m, exp_e[k], exp_m[k]);
            end
        end
    endtask

    task automatic test_fill_mask();
        logic signed [WIDTH-1:0] s, e, m;
        int lat;
        int ex;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            do_sample(32767, 1'b1, 4'd1, 8'd0, 8'd128, s, e, m, lat);
        end
        apply_reset();
        for (int k = 1; k <= 6; k++) begin
            do_sample(100 * k, 1'b1, 4'd5, 8'd0, 8'd128, s, e, m, lat);
            ex = (k == 6) ? 100 : 0;
            checks++;
            if (lat != 4 || int'(e) !== ex) begin
                errors++;
                $display("FAIL fill_mask out%0d: echo=%0d, required %0d", k, e, ex);
            end
        end
    endtask

    task automatic test_wrap();
        logic signed [WIDTH-1:0] s, e, m;
        int lat;
        int ex;
        int hist[23];
        logic [ADDR_W-1:0] d;
        apply_reset();
        for (int n = 1; n <= 22; n++) begin
            hist[n] = 10 * n;
            d = (n <= 20) ? 4'd6 : ((n == 21) ? 4'd0 : 4'd9);
            do_sample(hist[n], 1'b1, d, 8'd0, 8'd0, s, e, m, lat);
            if (n == 21)     ex = hist[20];
            else if (n >= 7) ex = hist[n - 6];
            else             ex = 0;
            checks++;
            if (lat != 4 || int'(e) !== ex || int'(m) !== hist[n] || int'(s) !== hist[n]) begin
                errors++;
                $display("FAIL wrap n=%0d d=%0d: echo=%0d mix=%0d sig=%0d, required echo=%0d mix=sig=%0d",
                         n, d, e, m, s, ex, hist[n]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ex_ov, ex_ovr, ex_busy;
        apply_reset();
        store_audio_in   = 1'b1;
        delay_in         = 4'd3;
        feedback_gain_in = 8'd0;
        mix_gain_in      = 8'd128;
        for (int c = 0; c < 10; c++) begin
            ex_ov   = (c == 4 || c == 8);
            ex_ovr  = (c >= 3);
            ex_busy = (c inside {1, 2, 3, 5, 6, 7});
            checks++;
            if (out_valid !== ex_ov || overrun_out !== ex_ovr || busy_out !== ex_busy) begin
                errors++;
                $display("FAIL back_to_back c%0d: ov=%b ovr=%b busy=%b, required %b %b %b",
                         c, out_valid, overrun_out, busy_out, ex_ov, ex_ovr, ex_busy);
            end
            if (ex_ov) begin
                checks++;
                if (int'(signal_out) !== ((c == 4) ? 111 : 333) || int'(mix_out) !== int'(signal_out)) begin
                    errors++;
                    $display("FAIL back_to_back data c%0d: sig=%0d mix=%0d, required %0d",
                             c, signal_out, mix_out, (c == 4) ? 111 : 333);
                end
            end
            audio_valid_in = (c == 0 || c == 2 || c == 4);
            audio_in       = (c == 0) ? 16'sd111 : ((c == 2) ? 16'sd222 : 16'sd333);
            @(negedge clk);
        end
        audio_valid_in = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic ex_ovr, ex_busy;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            ex_ovr  = (c == 2);
            ex_busy = (c == 1 || c == 2);
            checks++;
            if (out_valid !== 1'b0 || overrun_out !== ex_ovr || busy_out !== ex_busy) begin
                errors++;
                $display("FAIL reset_midflight c%0d: ov=%b ovr=%b busy=%b, required 0 %b %b",
                         c, out_valid, overrun_out, busy_out, ex_ovr, ex_busy);
            end
            audio_valid_in = (c == 0 || c == 1);
            audio_in       = 16'sd500;
            rst_in         = (c == 2);
            @(negedge clk);
        end
        audio_valid_in = 1'b0;
        rst_in         = 1'b0;
    endtask

    initial begin
        rst_in           = 1'b0;
        audio_valid_in   = 1'b0;
        audio_in         = '0;
        store_audio_in   = 1'b1;
        delay_in         = '0;
        feedback_gain_in = '0;
        mix_gain_in      = '0;
        test_reset();
        test_impulse();
        test_feedback();
        test_saturation();
        test_fill_mask();
        test_wrap();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
